// File: rtl/regfile_scoreboard.sv
// Dual-write, dual-read register file with optional write-to-read bypass and a
// per-register pending (scoreboard) bit used for pipeline hazard detection.
module regfile_scoreboard #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             ReadPending1,
  output logic             ReadPending2,
  input  logic [AW-1:0]    WriteRegisterA,
  input  logic [WIDTH-1:0] WriteDataA,
  input  logic             RegWriteA,
  input  logic [AW-1:0]    WriteRegisterB,
  input  logic [WIDTH-1:0] WriteDataB,
  input  logic             RegWriteB,
  input  logic [AW-1:0]    ReserveRegister,
  input  logic             Reserve,
  output logic             AnyPending
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic [DEPTH-1:0] w_wen;
  logic [DEPTH-1:0] w_res;
  logic [WIDTH-1:0] w_wdata [DEPTH];

  // Read-side view of one address: bypassed data first, then stored data.
  function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    v = r_regs[addr];
    if (BYPASS) begin
      if (RegWriteB && (WriteRegisterB == addr)) begin
        v = WriteDataB;
      end else if (RegWriteA && (WriteRegisterA == addr)) begin
        v = WriteDataA;
      end
    end
    if (!Reset_n || (ZERO_REG && (addr == '0))) begin
      v = '0;
    end
    return v;
  endfunction

  // A bypass hit means the producer is completing now, so the register is no
  // longer pending unless a new producer reserves it on the same edge.
  function automatic logic rd_pend(input logic [AW-1:0] addr);
    logic p;
    p = r_pend[addr];
    if (BYPASS) begin
      if ((RegWriteB && (WriteRegisterB == addr)) ||
          (RegWriteA && (WriteRegisterA == addr))) begin
        p = Reserve && (ReserveRegister == addr);
      end
    end
    if (!Reset_n || (ZERO_REG && (addr == '0))) begin
      p = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    w_wen = '0;
    w_res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wen[i] = (RegWriteA && (WriteRegisterA == AW'(i))) ||
                 (RegWriteB && (WriteRegisterB == AW'(i)));
      w_res[i] = Reserve && (ReserveRegister == AW'(i));
      // Port B has priority on a same-address collision.
      w_wdata[i] = (RegWriteB && (WriteRegisterB == AW'(i))) ? WriteDataB : WriteDataA;
      if (ZERO_REG && (i == 0)) begin
        w_wen[i] = 1'b0;
        w_res[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wen[i]) begin
          r_regs[i] <= w_wdata[i];
        end
        // A same-edge reserve is the newer producer and overrides the clear.
        if (w_res[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_wen[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign ReadData1    = rd_data(ReadRegister1);
  assign ReadData2    = rd_data(ReadRegister2);
  assign ReadPending1 = rd_pend(ReadRegister1);
  assign ReadPending2 = rd_pend(ReadRegister2);
  assign AnyPending   = |r_pend;

endmodule
